// File: rtl/fifo_array_reader.sv
// rtl/fifo_array_reader.sv - fifo_array read-side controller with skid buffer and frame marker
// Optional stall/starve counters: define FIFO_READER_STATS_EN.
module fifo_array_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_SIZE = 3,
    parameter int SKID_DEPTH = 2,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          fifo_empty_i,
    output logic                          fifo_rd_en_o,
    input  logic signed [DATA_WIDTH-1:0]  fifo_dout_i [ARRAY_SIZE],
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic signed [DATA_WIDTH-1:0]  out_data_o [ARRAY_SIZE],
    output logic                          out_last_o,
`ifdef FIFO_READER_STATS_EN
    output logic [$clog2(FRAME_LEN):0]    frame_idx_o,
    output logic [31:0]                   stall_cycles_o,
    output logic [31:0]                   starve_cycles_o
`else
    output logic [$clog2(FRAME_LEN):0]    frame_idx_o
`endif
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW = $clog2(SKID_DEPTH + 2) + 1;
    localparam int FW = $clog2(FRAME_LEN) + 1;

    logic signed [DATA_WIDTH-1:0] buf_q [SKID_DEPTH][ARRAY_SIZE];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          in_flight_q;
    logic [FW-1:0] frame_idx_q;
    logic          fire;
    logic [CW-1:0] occ_after;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid_o = (count_q != '0);
    assign fire        = out_valid_o && out_ready_i;

    // Occupancy after this cycle's fire, counting the vector still in the FIFO's read register.
    assign occ_after    = count_q + CW'(in_flight_q) - CW'(fire);
    assign fifo_rd_en_o = rst_n_i && !fifo_empty_i && (occ_after < CW'(SKID_DEPTH));

    always_comb begin
        for (int l = 0; l < ARRAY_SIZE; l++) begin
            out_data_o[l] = buf_q[head_q][l];
        end
    end

    assign out_last_o  = out_valid_o && (frame_idx_q == FW'(FRAME_LEN - 1));
    assign frame_idx_o = frame_idx_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int e = 0; e < SKID_DEPTH; e++) begin
                for (int l = 0; l < ARRAY_SIZE; l++) begin
                    buf_q[e][l] <= '0;
                end
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            in_flight_q <= 1'b0;
            frame_idx_q <= '0;
        end else begin
            in_flight_q <= fifo_rd_en_o;
            if (in_flight_q) begin
                for (int l = 0; l < ARRAY_SIZE; l++) begin
                    buf_q[tail_q][l] <= fifo_dout_i[l];
                end
                tail_q <= ptr_inc(tail_q);
            end
            if (fire) begin
                head_q      <= ptr_inc(head_q);
                frame_idx_q <= (frame_idx_q == FW'(FRAME_LEN - 1)) ? '0 : frame_idx_q + FW'(1);
            end
            case ({in_flight_q, fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [31:0] stall_q, starve_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (!out_valid_o && out_ready_i && (starve_q != '1)) begin
                starve_q <= starve_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o  = stall_q;
    assign starve_cycles_o = starve_q;
`endif

endmodule

// File: tb/tb_fifo_array_reader.sv
// tb/tb_fifo_array_reader.sv - directed self-checking bench for fifo_array_reader
// Stats checks run when FIFO_READER_STATS_EN is defined.
module tb_fifo_array_reader;

    localparam int DW   = 32;
    localparam int AS   = 3;
    localparam int SKID = 2;
    localparam int FLEN = 4;

    logic clk = 0;
    logic rst_n = 0;
    logic fifo_empty, fifo_rd_en, out_valid, out_ready = 0, out_last;
    logic signed [DW-1:0] dout_l [AS];
    logic signed [DW-1:0] od [AS];
    logic [2:0] frame_idx;
`ifdef FIFO_READER_STATS_EN
    logic [31:0] stall_cycles, starve_cycles;
`endif

    always #5 clk = ~clk;

    fifo_array_reader #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .SKID_DEPTH(SKID), .FRAME_LEN(FLEN)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(fifo_empty), .fifo_rd_en_o(fifo_rd_en),
        .fifo_dout_i(dout_l), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(od), .out_last_o(out_last),
`ifdef FIFO_READER_STATS_EN
        .frame_idx_o(frame_idx), .stall_cycles_o(stall_cycles), .starve_cycles_o(starve_cycles)
`else
        .frame_idx_o(frame_idx)
`endif
    );

    // FIFO model: one-cycle registered read, cleared by the block reset.
    logic [95:0] fq[$];
    logic [95:0] fdout = '0;
    int          fifo_n = 0;
    logic        hold = 1, force_ne = 0, push_en = 0;
    logic [95:0] push_d = '0;

    assign fifo_empty = force_ne ? 1'b0 : (hold || fifo_n == 0);
    assign dout_l[0] = fdout[31:0];
    assign dout_l[1] = fdout[63:32];
    assign dout_l[2] = fdout[95:64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fifo_n <= 0;
            fdout  <= '0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fdout <= fq.pop_front();
            if (push_en) fq.push_back(push_d);
            fifo_n <= fq.size();
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] vec(input int a, input int b, input int c);
        return {c[31:0], b[31:0], a[31:0]};
    endfunction

    typedef struct { logic [95:0] d; logic last; int idx; int cyc; } beat_t;
    beat_t beats[$];
    int cyc = 0, rd_cnt = 0, first_rd = -1, first_val = -1;
    logic        prev_hold = 0;
    logic [95:0] prev_data = '0;
    wire  [95:0] out_pk = {od[2], od[1], od[0]};

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (out_valid && first_val < 0) first_val = cyc;
            if (out_valid && out_ready) beats.push_back('{out_pk, out_last, int'(frame_idx), cyc});
            chk("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
            chk("overflow", (dut.count_q > SKID) ||
                (dut.count_q == SKID && dut.in_flight_q && !(out_valid && out_ready)), 0);
            if (prev_hold) begin
                chk("stall_valid_stable", out_valid, 1);
                chk("stall_data_stable", out_pk, prev_data);
            end
        end
        prev_hold = rst_n && out_valid && !out_ready;
        prev_data = out_pk;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0; out_ready = 0; hold = 1; force_ne = 0; push_en = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic push_vec(input logic [95:0] v);
        push_en = 1; push_d = v;
        @(posedge clk); #1;
        push_en = 0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k = 0;
        while (beats.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (beats.size() < n) chk({name, "_timeout"}, beats.size(), n);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) chk({name, "_valid_timeout"}, out_valid, 1);
    endtask

    typedef struct { logic rst; logic fne; logic fe; logic rdy; logic e_rd; logic e_val; int e_idx; } tv_t;
    tv_t tv[13];

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // {rst_n, force nonempty, force empty, ready, exp rd_en, exp valid, exp frame_idx}
        tv[0]  = '{0, 1, 0, 1, 0, 0, 0};
        tv[1]  = '{0, 1, 0, 1, 0, 0, 0};
        tv[2]  = '{0, 1, 0, 1, 0, 0, 0};
        tv[3]  = '{1, 0, 1, 1, 0, 0, 0};
        tv[4]  = '{1, 0, 1, 0, 0, 0, 0};
        tv[5]  = '{1, 1, 0, 0, 1, 0, 0};
        tv[6]  = '{1, 0, 1, 0, 0, 0, 0};
        tv[7]  = '{1, 0, 1, 0, 0, 1, 0};
        tv[8]  = '{1, 1, 0, 0, 1, 1, 0};
        tv[9]  = '{1, 1, 0, 0, 0, 1, 0};
        tv[10] = '{1, 1, 0, 0, 0, 1, 0};
        tv[11] = '{1, 1, 0, 1, 1, 1, 0};
        tv[12] = '{0, 0, 1, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            rst_n = tv[i].rst; force_ne = tv[i].fne; hold = tv[i].fe; out_ready = tv[i].rdy;
            @(negedge clk);
            chk($sformatf("tv%0d_rd_en", i), fifo_rd_en, tv[i].e_rd);
            chk($sformatf("tv%0d_valid", i), out_valid, tv[i].e_val);
            chk($sformatf("tv%0d_frame_idx", i), frame_idx, tv[i].e_idx);
            chk($sformatf("tv%0d_last", i), out_last, 0);
        end
        chk("reset_out_data", out_pk, 96'd0);

        // Streaming: 8 preloaded vectors, ready held high.
        do_reset();
        for (int i = 0; i < 8; i++) push_vec(vec(i, -i, 2 * i));
        beats.delete(); rd_cnt = 0; first_rd = -1; first_val = -1;
        out_ready = 1; hold = 0;
        wait_beats(8, 40, "stream");
        repeat (4) @(negedge clk);
        chk("stream_latency", first_val - first_rd, 2);
        chk("stream_rd_pulses", rd_cnt, 8);
        chk("stream_beats", beats.size(), 8);
        if (beats.size() == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("stream_beat%0d", i), beats[i].d, vec(i, -i, 2 * i));
            chk("stream_no_bubbles", beats[7].cyc - beats[0].cyc, 7);
        end

        // Backpressure: 6 vectors, stall for 10 cycles after beat 0.
        do_reset();
        for (int i = 0; i < 6; i++) push_vec(vec(100 + i, -100 - i, 3 * i));
        beats.delete();
        hold = 0;
        wait_valid(10, "bp");
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data%0d", i), out_pk, vec(101, -101, 3));
            chk($sformatf("bp_buffered%0d", i), dut.count_q <= SKID, 1);
        end
        @(posedge clk); #1 out_ready = 1;
        wait_beats(6, 30, "bp");
        repeat (4) @(negedge clk);
        chk("bp_beat_count", beats.size(), 6);
        if (beats.size() >= 6)
            for (int i = 0; i < 6; i++) chk($sformatf("bp_beat%0d", i), beats[i].d, vec(100 + i, -100 - i, 3 * i));

        // Frame marker with FRAME_LEN=4 over 10 vectors.
        do_reset();
        for (int i = 0; i < 10; i++) push_vec(vec(7 * i, -7 * i, i));
        beats.delete();
        out_ready = 1; hold = 0;
        wait_beats(10, 40, "frame");
        repeat (3) @(negedge clk);
        chk("frame_idx_after", frame_idx, 2);
        if (beats.size() >= 10)
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("frame_last%0d", i), beats[i].last, (i % 4) == 3);
                chk($sformatf("frame_idx%0d", i), beats[i].idx, i % 4);
            end

        // Reset mid-stream with one vector buffered and one in flight.
        do_reset();
        for (int i = 0; i < 5; i++) push_vec(vec(50 + i, -50 - i, i));
        hold = 0;
        begin
            int k = 0;
            @(negedge clk);
            while (!(dut.count_q == 1 && dut.in_flight_q) && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("mid_reached_state", dut.count_q == 1 && dut.in_flight_q, 1);
        end
        rst_n = 0;
        #1;
        chk("mid_valid_async", out_valid, 0);
        chk("mid_rd_en", fifo_rd_en, 0);
        chk("mid_frame_idx", frame_idx, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        beats.delete();
        out_ready = 1;
        push_vec(vec(77, -77, 154));
        wait_beats(1, 20, "mid");
        if (beats.size() >= 1) chk("mid_first_beat", beats[0].d, vec(77, -77, 154));

`ifdef FIFO_READER_STATS_EN
        // Stats: 5 stall cycles then 3 starve cycles.
        do_reset();
        chk("stats_reset_stall", stall_cycles, 0);
        chk("stats_reset_starve", starve_cycles, 0);
        push_vec(vec(1, 2, 3));
        hold = 0;
        wait_valid(10, "stats");
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("stats_stall", stall_cycles, 5);
        chk("stats_starve", starve_cycles, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
